// File: rtl/seg7_scan_decoder.sv
// Recovers the four BCD digits shown on a multiplexed, active-low 7-segment display
// by watching its scan lines, and reports a frame only after it has been seen stable.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  an_i,
  output logic [15:0] bcd_out_o,
  output logic [3:0]  blank_mask_o,
  output logic        frame_valid_o,
  output logic        decode_err_o,
  output logic        stale_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {WAIT_AN, SETTLE, SAMPLE} state_t;

  state_t        state_q, state_d;
  logic [6:0]    segMeta_q, segSync_q, segPrev_q;
  logic [3:0]    anMeta_q, anSync_q, anPrev_q;
  logic [SW-1:0] settleCnt_q, settleCnt_d;
  logic [3:0]    lastAn_q, lastAn_d;
  logic [15:0]   digits_q, digits_d, prevDigits_q, prevDigits_d, bcd_q, bcd_d;
  logic [3:0]    blanks_q, blanks_d, prevBlanks_q, prevBlanks_d, blankOut_q, blankOut_d;
  logic [3:0]    capMask_q, capMask_d;
  logic          errFlag_q, errFlag_d;
  logic [MW-1:0] matchCnt_q, matchCnt_d;
  logic [TW-1:0] timeoutCnt_q, timeoutCnt_d;
  logic          stale_q, stale_d, frameValid_q, frameValid_d, decodeErr_q, decodeErr_d;

  logic       anValid, changed, sampleEn, sameFrame;
  logic [6:0] segHigh;
  logic [3:0] decDigit;
  logic       decBlank, decIllegal;
  logic [1:0] slot;

  assign anValid = (anSync_q == 4'b1110) || (anSync_q == 4'b1101) ||
                   (anSync_q == 4'b1011) || (anSync_q == 4'b0111);
  assign changed = (segSync_q != segPrev_q) || (anSync_q != anPrev_q);

  // The sample cycle decodes the values that were proven stable in the last settle cycle.
  assign segHigh = ~segPrev_q;

  always_comb begin
    decDigit   = 4'd0;
    decBlank   = 1'b0;
    decIllegal = 1'b0;
    case (segHigh)
      7'b0111111: decDigit = 4'd0;
      7'b0000110: decDigit = 4'd1;
      7'b1011011: decDigit = 4'd2;
      7'b1001111: decDigit = 4'd3;
      7'b1100110: decDigit = 4'd4;
      7'b1101101: decDigit = 4'd5;
      7'b1111101: decDigit = 4'd6;
      7'b0000111: decDigit = 4'd7;
      7'b1111111: decDigit = 4'd8;
      7'b1101111: decDigit = 4'd9;
      7'b0000000: decBlank = 1'b1;
      default:    decIllegal = 1'b1;
    endcase
  end

  always_comb begin
    slot = 2'd0;
    case (anPrev_q)
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    sampleEn    = 1'b0;
    case (state_q)
      WAIT_AN: begin
        if (anValid && (anSync_q != lastAn_q)) begin
          state_d     = SETTLE;
          settleCnt_d = '0;
        end
      end
      SETTLE: begin
        if (!anValid) begin
          state_d = WAIT_AN;
        end else if (changed) begin
          settleCnt_d = '0;
        end else if (settleCnt_q == SETTLE_MAX) begin
          state_d = SAMPLE;
        end else begin
          settleCnt_d = settleCnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        sampleEn = 1'b1;
        state_d  = WAIT_AN;
      end
      default: state_d = WAIT_AN;
    endcase
  end

  // Frame assembly, stability matching and staleness tracking.
  always_comb begin
    digits_d     = digits_q;
    blanks_d     = blanks_q;
    capMask_d    = capMask_q;
    errFlag_d    = errFlag_q;
    prevDigits_d = prevDigits_q;
    prevBlanks_d = prevBlanks_q;
    matchCnt_d   = matchCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    stale_d      = stale_q;
    bcd_d        = bcd_q;
    blankOut_d   = blankOut_q;
    lastAn_d     = lastAn_q;
    frameValid_d = 1'b0;
    decodeErr_d  = 1'b0;
    sameFrame    = 1'b0;
    if (sampleEn) begin
      digits_d[{slot, 2'b00} +: 4] = decDigit;
      blanks_d[slot]  = decBlank;
      capMask_d[slot] = 1'b1;
      errFlag_d       = errFlag_q | decIllegal;
      lastAn_d        = anPrev_q;
      timeoutCnt_d    = '0;
      stale_d         = 1'b0;
      if (capMask_d == 4'hF) begin
        capMask_d = 4'h0;
        errFlag_d = 1'b0;
        if (errFlag_q || decIllegal) begin
          decodeErr_d = 1'b1;
          matchCnt_d  = '0;
        end else begin
          sameFrame = (digits_d == prevDigits_q) && (blanks_d == prevBlanks_q);
          if (!sameFrame) begin
            matchCnt_d = MW'(1);
          end else if (matchCnt_q != MATCH_MAX) begin
            matchCnt_d = matchCnt_q + 1'b1;
          end
          prevDigits_d = digits_d;
          prevBlanks_d = blanks_d;
          if ((matchCnt_d == MATCH_MAX) && !(sameFrame && (matchCnt_q == MATCH_MAX))) begin
            bcd_d        = digits_d;
            blankOut_d   = blanks_d;
            frameValid_d = 1'b1;
          end
        end
      end
    end else if (timeoutCnt_q != TIMEOUT_MAX) begin
      timeoutCnt_d = timeoutCnt_q + 1'b1;
      if (timeoutCnt_d == TIMEOUT_MAX) begin
        stale_d    = 1'b1;
        capMask_d  = 4'h0;
        errFlag_d  = 1'b0;
        matchCnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      segMeta_q    <= '0;
      segSync_q    <= '0;
      segPrev_q    <= '0;
      anMeta_q     <= '0;
      anSync_q     <= '0;
      anPrev_q     <= '0;
      state_q      <= WAIT_AN;
      settleCnt_q  <= '0;
      lastAn_q     <= '0;
      digits_q     <= '0;
      blanks_q     <= '0;
      capMask_q    <= '0;
      errFlag_q    <= 1'b0;
      prevDigits_q <= '0;
      prevBlanks_q <= '0;
      matchCnt_q   <= '0;
      timeoutCnt_q <= '0;
      stale_q      <= 1'b0;
      bcd_q        <= '0;
      blankOut_q   <= '0;
      frameValid_q <= 1'b0;
      decodeErr_q  <= 1'b0;
    end else begin
      segMeta_q    <= seg_i;
      segSync_q    <= segMeta_q;
      segPrev_q    <= segSync_q;
      anMeta_q     <= an_i;
      anSync_q     <= anMeta_q;
      anPrev_q     <= anSync_q;
      state_q      <= state_d;
      settleCnt_q  <= settleCnt_d;
      lastAn_q     <= lastAn_d;
      digits_q     <= digits_d;
      blanks_q     <= blanks_d;
      capMask_q    <= capMask_d;
      errFlag_q    <= errFlag_d;
      prevDigits_q <= prevDigits_d;
      prevBlanks_q <= prevBlanks_d;
      matchCnt_q   <= matchCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
      stale_q      <= stale_d;
      bcd_q        <= bcd_d;
      blankOut_q   <= blankOut_d;
      frameValid_q <= frameValid_d;
      decodeErr_q  <= decodeErr_d;
    end
  end

  assign bcd_out_o     = bcd_q;
  assign blank_mask_o  = blankOut_q;
  assign frame_valid_o = frameValid_q;
  assign decode_err_o  = decodeErr_q;
  assign stale_o       = stale_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Parameters
REQ-001 SHALL provide SETTLE_CYCLES, default 4: consecutive stable cycles of synchronized seg/an required before a digit is sampled.
REQ-002 SHALL provide STABLE_FRAMES, default 2: consecutive identical complete frames required before outputs update.
REQ-003 SHALL provide TIMEOUT_CYCLES, default 65536: cycles without a valid sample before the frame is declared stale.

Interface
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low; low clears all state.
REQ-007 seg  input  7  scanned segment lines {g,f,e,d,c,b,a}, active-low, asynchronous to clk.
REQ-008 an  input  4  scanned digit enables, active-low, asynchronous to clk; an[0] is the least-significant digit.
REQ-009 bcd_out  output  16  last accepted frame; digit k at bcd_out[4k+3:4k].
REQ-010 blank_mask  output  4  bit k set when digit k of the accepted frame was blank.
REQ-011 frame_valid  output  1  one-cycle pulse when bcd_out/blank_mask update.
REQ-012 decode_err  output  1  one-cycle pulse when a frame is discarded for an illegal pattern.
REQ-013 stale  output  1  level; high while the timeout is expired.

Function
REQ-014 seg and an SHALL each pass a 2-flop synchronizer; all logic uses synchronized copies only.
REQ-015 An an value is valid only when exactly one bit is low; all-high or multi-low values SHALL be ignored and SHALL restart settling.
REQ-016 FSM states: WAIT_AN, SETTLE, SAMPLE; reset state WAIT_AN.
REQ-017 WAIT_AN -> SETTLE on a valid an; settle counter loads 0.
REQ-018 SETTLE: counter increments each cycle seg and an are unchanged; any change reloads 0 (returns to WAIT_AN if an becomes invalid); at SETTLE_CYCLES -> SAMPLE.
REQ-019 SAMPLE lasts one cycle: decodes seg, writes the slot selected by an, sets its captured-mask bit, then -> WAIT_AN, which is left only when an differs from the sampled value.
REQ-020 Decode, active-high gfedcba: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; 0000000 = blank (digit 0, blank bit set); any other pattern SHALL mark the frame in error.
REQ-021 A frame is complete when all four captured-mask bits are set; on completion the mask clears the next cycle.
REQ-022 Re-sampling an already-captured slot before completion SHALL overwrite that slot without setting error.
REQ-023 Complete error-free frame equal (digits and blank bits) to the previous complete frame increments a match counter, otherwise loads 1; at STABLE_FRAMES, bcd_out/blank_mask update and frame_valid pulses in the same cycle; match counter saturates and further identical frames produce no pulse.
REQ-024 Complete frame with error SHALL pulse decode_err, leave outputs unchanged, and zero the match counter.
REQ-025 Timeout counter resets on every SAMPLE; at TIMEOUT_CYCLES stale asserts, mask and match counter clear, counter holds; stale deasserts on the next SAMPLE. bcd_out holds.
REQ-026 Latency: seg/an change to SAMPLE = 2 (sync) + SETTLE_CYCLES + 1 cycles.

Reset
REQ-027 While reset is low: bcd_out=0, blank_mask=0, frame_valid=0, decode_err=0, stale=0, FSM=WAIT_AN, all counters/masks/synchronizers cleared.
REQ-028 Reset low mid-frame SHALL discard the partial frame; first frame_valid after release requires STABLE_FRAMES fresh complete frames.

Verification
REQ-029 Scan "0012" (an cycling 1110,1101,1011,0111, 32 clk/digit), 3 frames -> one frame_valid, bcd_out=16'h0012, blank_mask=0.
REQ-030 Digit 3 blank, digit 2 = 7, scanned 2 frames -> bcd_out=16'h0705... with blank_mask=4'b1000, digit 3 field=0.
REQ-031 Frame with seg=1110000 (illegal) on digit 1 -> decode_err pulse, no frame_valid, bcd_out unchanged.
REQ-032 seg toggles every 2 clk while an steady -> no SAMPLE, no captured bits, no output change.
REQ-033 Scanning stops, an=1111 for TIMEOUT_CYCLES -> stale=1, bcd_out holds; scanning resumes -> stale=0 at first SAMPLE.
REQ-034 reset low after two digits captured, then valid scan "1234" -> frame_valid only after 2 complete frames, bcd_out=16'h1234.
